mips_multicycle_ctrl: RTL

Main control unit for the multicycle variant of the MIPS core. A Moore state machine sequences a shared-memory datapath: one memory (instruction and data), one ALU (also used for PC+4 and branch target), and the instruction, data, A/B and ALUOut registers. The block sits beside the datapath inside the core. It sees only the instruction fields and the ALU zero flag, and drives every mux select and write enable.

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/mips_multicycle_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcodes, funct codes, ALU control and ALUOp.
package mips_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALUOp + funct to ALUControl; flags funct codes
// the datapath does not implement.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: bad_funct   = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the shared-memory multicycle MIPS
// datapath; drives every mux select and write enable.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       instr_done,
  output logic       illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;
  logic               skip_wb_q, skip_wb_d;
  state_t             state, nxt;
  logic [1:0]         alu_op;
  logic               bad_funct;
  logic               pc_write;
  logic               branch;

  assign state = state_t'(state_q[STATE_BITS-1:0]);
  assign illegal = illegal_q;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (ALUControl),
    .bad_funct   (bad_funct)
  );

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    nxt        = state;
    illegal_d  = illegal_q;
    skip_wb_d  = skip_wb_q;

    if (reset) begin
      // FETCH selects, but every write enable held off
      ALUSrcB   = 2'b01;
      nxt       = S_FETCH;
      illegal_d = 1'b0;
      skip_wb_d = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          IRWrite  = 1'b1;
          ALUSrcB  = 2'b01;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default: begin
              nxt        = S_FETCH;
              illegal_d  = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          IorD = 1'b1;
          nxt  = S_MEMWB;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA   = 1'b1;
          alu_op    = ALUOP_FUNCT;
          skip_wb_d = bad_funct;
          illegal_d = illegal_q | bad_funct;
          nxt       = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = ~skip_wb_q;
          instr_done = 1'b1;
          skip_wb_d  = 1'b0;
          nxt        = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          alu_op     = ALUOP_SUB;
          PCSrc      = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt     = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end

    PCEn    = pc_write | (branch & zero);
    state_d = STATE_W'(nxt);
  end

  always_ff @(posedge clock) begin
    state_q   <= state_d;
    illegal_q <= illegal_d;
    skip_wb_q <= skip_wb_d;
  end

endmodule
